uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller: owns the oversampling edge counter, bit counter, 3-sample majority sampler, deserializer, parity and stop checking, and the frame state machine. It is the next-generation RX path in the UART subsystem and replaces the fixed 8-bit, single-stop, even-parity controller. It adds configurable data width, odd/even parity, one or two stop bits, and per-frame configuration latching.

---
 rtl/uart_rx_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// UART receive controller with configurable data width, optional odd/even
// parity and one or two stop bits. The frame configuration (prescale, parity
// enable/type, stop-bit count) is captured on the start-detection cycle and
// held for the whole frame, so the configuration inputs may change freely
// while a frame is in flight.
//
// Each bit is oversampled: the line is captured at the three edges centred
// on mid-bit (P/2-1, P/2, P/2+1) and the bit is resolved by majority vote at
// the last edge of the bit (P-1).
//
// Parameters
//   DATA_W      data bits per frame (5..9)
//   PRESCALE_W  width of the prescale input
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active low
//   rx_in       serial line, synchronised to clk, idles high
//   prescale    clocks per bit (8, 16 or 32)
//   par_en      a parity bit follows the data bits
//   par_typ     0 = even parity, 1 = odd parity
//   stop2       0 = one stop bit, 1 = two stop bits
//   data_out    last frame received without error, LSB received first
//   data_valid  one-cycle pulse when data_out is updated
//   par_err     one-cycle pulse at frame end on parity mismatch
//   stp_err     one-cycle pulse at frame end if any stop bit sampled low
//   str_glitch  one-cycle pulse when a start bit is rejected
//   busy        high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  stop2,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  str_glitch,
    output logic                  busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state, state_nxt;
    logic [PRESCALE_W-1:0]   edge_cnt, edge_nxt;
    logic [CNT_W-1:0]        bit_cnt, bit_nxt;
    logic [2:0]              smp, smp_nxt;
    logic [DATA_W-1:0]       shreg, shreg_nxt;
    logic [DATA_W-1:0]       data_nxt;
    logic                    pe, pe_nxt;
    logic                    se, se_nxt;
    logic                    dv_nxt, perr_nxt, serr_nxt, glitch_nxt;

    logic [PRESCALE_W-1:0]   pscl_q, pscl_nxt;
    logic                    par_en_q, par_en_nxt;
    logic                    par_typ_q, par_typ_nxt;
    logic                    stop2_q, stop2_nxt;

    logic [PRESCALE_W-1:0]   half;
    logic [PRESCALE_W-1:0]   bit_end;
    logic                    at_end;
    logic                    maj;
    logic                    last_data;
    logic                    last_stop;
    logic                    par_exp;
    logic                    se_v;

    // Bit-timing landmarks, all derived from the prescale latched at start.
    assign half      = pscl_q >> 1;
    assign bit_end   = pscl_q - PRESCALE_W'(1);
    assign at_end    = (edge_cnt == bit_end);

    // Two-of-three vote over the mid-bit samples; all three are registered
    // well before the bit end for every legal prescale.
    assign maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

    assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
    assign last_stop = (bit_cnt == CNT_W'(stop2_q));
    assign par_exp   = (^shreg) ^ par_typ_q;

    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            smp        <= '0;
            shreg      <= '0;
            data_out   <= '0;
            pe         <= 1'b0;
            se         <= 1'b0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            str_glitch <= 1'b0;
            pscl_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            smp        <= smp_nxt;
            shreg      <= shreg_nxt;
            data_out   <= data_nxt;
            pe         <= pe_nxt;
            se         <= se_nxt;
            data_valid <= dv_nxt;
            par_err    <= perr_nxt;
            stp_err    <= serr_nxt;
            str_glitch <= glitch_nxt;
            pscl_q     <= pscl_nxt;
            par_en_q   <= par_en_nxt;
            par_typ_q  <= par_typ_nxt;
            stop2_q    <= stop2_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        edge_nxt    = edge_cnt;
        bit_nxt     = bit_cnt;
        smp_nxt     = smp;
        shreg_nxt   = shreg;
        data_nxt    = data_out;
        pe_nxt      = pe;
        se_nxt      = se;
        dv_nxt      = 1'b0;
        perr_nxt    = 1'b0;
        serr_nxt    = 1'b0;
        glitch_nxt  = 1'b0;
        pscl_nxt    = pscl_q;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        stop2_nxt   = stop2_q;
        se_v        = se;

        // Inside a frame the edge counter free-runs over 0..P-1 and the
        // mid-bit samples are captured at their fixed positions.
        if (state != IDLE) begin
            edge_nxt = at_end ? '0 : (edge_cnt + PRESCALE_W'(1));
            if (edge_cnt == (half - PRESCALE_W'(1))) smp_nxt[0] = rx_in;
            if (edge_cnt == half)                    smp_nxt[1] = rx_in;
            if (edge_cnt == (half + PRESCALE_W'(1))) smp_nxt[2] = rx_in;
        end

        case (state)
            IDLE: begin
                // The detection cycle is edge 0 of the start bit, so the
                // counter resumes at 1.
                if (!rx_in) begin
                    state_nxt   = START;
                    edge_nxt    = PRESCALE_W'(1);
                    bit_nxt     = '0;
                    pe_nxt      = 1'b0;
                    se_nxt      = 1'b0;
                    pscl_nxt    = prescale;
                    par_en_nxt  = par_en;
                    par_typ_nxt = par_typ;
                    stop2_nxt   = stop2;
                end
            end

            START: begin
                if (at_end) begin
                    if (maj) begin
                        glitch_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        state_nxt  = DATA;
                        bit_nxt    = '0;
                    end
                end
            end

            DATA: begin
                // Shift right so the first received bit ends up at bit 0.
                if (at_end) begin
                    shreg_nxt = {maj, shreg[DATA_W-1:1]};
                    if (last_data) begin
                        bit_nxt   = '0;
                        state_nxt = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_nxt   = bit_cnt + CNT_W'(1);
                    end
                end
            end

            PARITY: begin
                if (at_end) begin
                    if (maj != par_exp) pe_nxt = 1'b1;
                    state_nxt = STOP;
                end
            end

            STOP: begin
                // bit_cnt indexes the stop bit; the current bit's vote is
                // folded in directly so the final report needs no extra cycle.
                if (at_end) begin
                    se_v   = se | ~maj;
                    se_nxt = se_v;
                    if (last_stop) begin
                        state_nxt = IDLE;
                        bit_nxt   = '0;
                        perr_nxt  = pe;
                        serr_nxt  = se_v;
                        if (!pe && !se_v) begin
                            data_nxt = shreg;
                            dv_nxt   = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Directed bench for uart_rx_ctrl. Two instances are used: an 8-bit one for
// most frames and a 7-bit one for the odd-parity / two-stop-bit frame. Each
// scenario builds a per-cycle line waveform (and prescale value) in queues;
// cycle 0 of the waveform is the start-detection cycle. Outputs are sampled
// on the falling edge and summarised (first/last cycle and count of every
// pulse), then compared with hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx8, rx7;
    logic [5:0] prescale;
    logic       par_en, par_typ, stop2;

    logic [7:0] d8;
    logic       dv8, pe8, se8, gl8, busy8;
    logic [6:0] d7;
    logic       dv7, pe7, se7, gl7, busy7;

    int total_cnt = 0;
    int bad_cnt   = 0;

    logic wave[$];
    int   psq[$];

    int dv_cnt, dv_first, dv_last, dv_data_first;
    int pe_cnt, pe_first, se_cnt, se_first, gl_cnt, gl_first;
    int busy_cnt, busy_first, busy_last, last_data;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(8), .PRESCALE_W(6)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx8),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .data_out   (d8),
        .data_valid (dv8),
        .par_err    (pe8),
        .stp_err    (se8),
        .str_glitch (gl8),
        .busy       (busy8)
    );

    uart_rx_ctrl #(.DATA_W(7), .PRESCALE_W(6)) dut7 (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx7),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .stop2      (stop2),
        .data_out   (d7),
        .data_valid (dv7),
        .par_err    (pe7),
        .stp_err    (se7),
        .str_glitch (gl7),
        .busy       (busy7)
    );

    task automatic check_output(input string tag, input int actual, input int expected);
        total_cnt++;
        if (actual != expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic add_bits(input logic b, input int n, input int p);
        for (int i = 0; i < n; i++) begin
            wave.push_back(b);
            psq.push_back(p);
        end
    endtask

    task automatic add_frame(input logic [8:0] data, input int nbits, input bit par_on,
                             input logic par_bit, input int nstop,
                             input logic [1:0] stop_vals, input int p);
        add_bits(1'b0, p, p);
        for (int i = 0; i < nbits; i++) add_bits(data[i], p, p);
        if (par_on) add_bits(par_bit, p, p);
        for (int i = 0; i < nstop; i++) add_bits(stop_vals[i], p, p);
    endtask

    task automatic clear_wave();
        wave.delete();
        psq.delete();
    endtask

    // Plays the queued waveform into one instance for ncyc cycles and
    // records when each output pulse was seen. rst is pulsed low for the
    // whole of cycle rst_cycle (-1 for none).
    task automatic apply_stimulus(input int which, input int ncyc, input int rst_cycle);
        logic line;
        int   o_d;
        logic o_dv, o_pe, o_se, o_gl, o_busy;
        dv_cnt = 0; dv_first = -1; dv_last = -1; dv_data_first = -1;
        pe_cnt = 0; pe_first = -1; se_cnt = 0; se_first = -1;
        gl_cnt = 0; gl_first = -1;
        busy_cnt = 0; busy_first = -1; busy_last = -1; last_data = -1;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            if (k < wave.size()) begin
                line     = wave[k];
                prescale = 6'(psq[k]);
            end else begin
                line = 1'b1;
            end
            rx8 = (which == 8) ? line : 1'b1;
            rx7 = (which == 7) ? line : 1'b1;
            rst = (k == rst_cycle) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (which == 7) begin
                o_d = int'(d7); o_dv = dv7; o_pe = pe7; o_se = se7; o_gl = gl7; o_busy = busy7;
            end else begin
                o_d = int'(d8); o_dv = dv8; o_pe = pe8; o_se = se8; o_gl = gl8; o_busy = busy8;
            end
            if (o_dv) begin
                dv_cnt++;
                if (dv_first < 0) begin
                    dv_first      = k;
                    dv_data_first = o_d;
                end
                dv_last = k;
            end
            if (o_pe) begin
                pe_cnt++;
                if (pe_first < 0) pe_first = k;
            end
            if (o_se) begin
                se_cnt++;
                if (se_first < 0) se_first = k;
            end
            if (o_gl) begin
                gl_cnt++;
                if (gl_first < 0) gl_first = k;
            end
            if (o_busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
                busy_last = k;
            end
            last_data = o_d;
        end
    endtask

    initial begin
        rst      = 1'b0;
        rx8      = 1'b1;
        rx7      = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        stop2    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("reset data_out", int'(d8), 0);
        check_output("reset data_valid", int'(dv8), 0);
        check_output("reset busy", int'(busy8), 0);
        check_output("reset err/glitch", int'({pe8, se8, gl8}), 0);
        check_output("reset busy7", int'(busy7), 0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) @(posedge clk);

        // 8N1, P=8, 0xA5
        $display("[TB] 8N1 P=8 byte 0xA5");
        clear_wave();
        add_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 8);
        apply_stimulus(8, 90, -1);
        check_output("t1 dv count", dv_cnt, 1);
        check_output("t1 dv cycle", dv_first, 80);
        check_output("t1 data", dv_data_first, 'hA5);
        check_output("t1 busy first", busy_first, 1);
        check_output("t1 busy last", busy_last, 79);
        check_output("t1 busy cycles", busy_cnt, 79);
        check_output("t1 errors", pe_cnt + se_cnt + gl_cnt, 0);

        // 8E1, P=16, 0x3C with a wrong parity bit
        $display("[TB] 8E1 P=16 byte 0x3C bad parity");
        par_en  = 1'b1;
        par_typ = 1'b0;
        clear_wave();
        add_frame(9'h03C, 8, 1'b1, 1'b1, 1, 2'b11, 16);
        apply_stimulus(8, 190, -1);
        check_output("t2 par_err count", pe_cnt, 1);
        check_output("t2 par_err cycle", pe_first, 176);
        check_output("t2 dv count", dv_cnt, 0);
        check_output("t2 stp_err count", se_cnt, 0);
        check_output("t2 data held", last_data, 'hA5);
        check_output("t2 busy last", busy_last, 175);

        // Start glitch, P=8: low for three cycles only
        $display("[TB] start glitch P=8");
        par_en = 1'b0;
        clear_wave();
        add_bits(1'b0, 3, 8);
        add_bits(1'b1, 17, 8);
        apply_stimulus(8, 20, -1);
        check_output("t3 glitch count", gl_cnt, 1);
        check_output("t3 glitch cycle", gl_first, 8);
        check_output("t3 dv count", dv_cnt, 0);
        check_output("t3 busy last", busy_last, 7);

        // DATA_W=7, odd parity, two stop bits, second stop low
        $display("[TB] 7O2 P=16 data 0x55 second stop low");
        par_en  = 1'b1;
        par_typ = 1'b1;
        stop2   = 1'b1;
        clear_wave();
        add_frame(9'h055, 7, 1'b1, 1'b1, 2, 2'b01, 16);
        apply_stimulus(7, 190, -1);
        check_output("t4 stp_err count", se_cnt, 1);
        check_output("t4 stp_err cycle", se_first, 176);
        check_output("t4 par_err count", pe_cnt, 0);
        check_output("t4 dv count", dv_cnt, 0);
        check_output("t4 busy last", busy_last, 175);

        // Noise rejection: one inverted cycle at edge 8 of data bit 3
        $display("[TB] noise in data bit 3");
        par_en  = 1'b0;
        par_typ = 1'b0;
        stop2   = 1'b0;
        clear_wave();
        add_frame(9'h05A, 8, 1'b0, 1'b0, 1, 2'b11, 16);
        wave[72] = ~wave[72];
        apply_stimulus(8, 170, -1);
        check_output("t5 dv count", dv_cnt, 1);
        check_output("t5 dv cycle", dv_first, 160);
        check_output("t5 data", dv_data_first, 'h5A);

        // Back-to-back frames, prescale disturbed during frame 1 only
        $display("[TB] back-to-back with prescale change");
        clear_wave();
        add_frame(9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11, 8);
        add_frame(9'h07E, 8, 1'b0, 1'b0, 1, 2'b11, 8);
        for (int i = 20; i < 60; i++) psq[i] = 16;
        apply_stimulus(8, 170, -1);
        check_output("t6 dv count", dv_cnt, 2);
        check_output("t6 dv first", dv_first, 80);
        check_output("t6 dv last", dv_last, 160);
        check_output("t6 data 1", dv_data_first, 'hC3);
        check_output("t6 data 2", last_data, 'h7E);
        check_output("t6 busy cycles", busy_cnt, 158);

        // Reset in cycle 40 of a frame
        $display("[TB] reset mid-frame");
        clear_wave();
        add_frame(9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 8);
        for (int i = 40; i < wave.size(); i++) wave[i] = 1'b1;
        apply_stimulus(8, 100, 40);
        check_output("t7 dv count", dv_cnt, 0);
        check_output("t7 pulses", pe_cnt + se_cnt + gl_cnt, 0);
        check_output("t7 data", last_data, 0);
        check_output("t7 busy last", busy_last, 39);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
